// File: rtl/fetch_stage_if.sv
// fetch_stage_if: signal bundle between the fetch stage and its neighbours.
//   Redirects   : flush, flush_addr (pipeline), jump_pred_IF, jump_addr_IF (decode)
//   Decode side : valid_out / ready_in handshake with PC_IF, IR_IF,
//                 exc_pend_IF, exc_cause_IF
//   Memory side : imem_valid_out / imem_ready_in request with imem_addr,
//                 imem_valid_in response with imem_rdata, imem_err
// master = fetch stage, slave = decode/memory environment.
interface fetch_stage_if;
  logic        flush;
  logic [31:0] flush_addr;
  logic        jump_pred_IF;
  logic [31:0] jump_addr_IF;

  logic        valid_out;
  logic        ready_in;
  logic [31:0] PC_IF;
  logic [31:0] IR_IF;
  logic        exc_pend_IF;
  logic [31:0] exc_cause_IF;

  logic        imem_valid_out;
  logic        imem_ready_in;
  logic [31:0] imem_addr;
  logic        imem_valid_in;
  logic [31:0] imem_rdata;
  logic        imem_err;

  modport master (
    input  flush, flush_addr, jump_pred_IF, jump_addr_IF, ready_in,
           imem_ready_in, imem_valid_in, imem_rdata, imem_err,
    output valid_out, PC_IF, IR_IF, exc_pend_IF, exc_cause_IF,
           imem_valid_out, imem_addr
  );

  modport slave (
    output flush, flush_addr, jump_pred_IF, jump_addr_IF, ready_in,
           imem_ready_in, imem_valid_in, imem_rdata, imem_err,
    input  valid_out, PC_IF, IR_IF, exc_pend_IF, exc_cause_IF,
           imem_valid_out, imem_addr
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage feeding decode.
//   Holds the PC, issues one-word requests to instruction memory (at most one
//   outstanding), buffers returned words in a 2-entry queue and presents the
//   head to decode. Redirects on flush (highest priority) or on a predicted
//   jump reported by decode when it accepts the head entry.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : fetch_stage_if.master (redirect inputs, decode and memory handshakes)
module fetch_stage #(
  parameter logic [31:0] RESET_ADDR         = 32'h0000_0000,
  parameter logic [31:0] CAUSE_MISALIGNED   = 32'd0,
  parameter logic [31:0] CAUSE_ACCESS_FAULT = 32'd1
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pc;
  logic        r_out;        // one request accepted, response pending
  logic        r_drop;       // next response must be discarded
  logic [31:0] r_ret_addr;   // address of the outstanding request
  logic        r_req_busy;   // request asserted but not yet accepted
  logic [31:0] r_req_addr;
  logic        r_req_stale;  // held request was redirected away from

  logic [31:0] r_q_pc    [2];
  logic [31:0] r_q_ir    [2];
  logic        r_q_exc   [2];
  logic [31:0] r_q_cause [2];
  logic        r_head;
  logic [1:0]  r_count;

  logic        w_head_valid;
  logic        w_valid_out;
  logic        w_pop;
  logic        w_jump;
  logic        w_kill;
  logic        w_resp;
  logic        w_resp_take;
  logic        w_resp_fault;
  logic [2:0]  w_level;
  logic        w_slot_free;
  logic        w_can_issue;
  logic        w_synth;
  logic        w_new_req;
  logic        w_imem_valid;
  logic [31:0] w_imem_addr;
  logic        w_accept;
  logic        w_acc_stale;
  logic        w_push;
  logic        w_wr_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_head_valid  = (r_count != 2'd0);
    w_valid_out   = w_head_valid && !bus.flush;
    w_pop         = w_valid_out && bus.ready_in;
    w_jump        = w_pop && bus.jump_pred_IF;
    w_kill        = bus.flush || w_jump;
    w_resp        = bus.imem_valid_in && r_out;
    // A response arriving with a redirect belongs to the abandoned path.
    w_resp_take   = w_resp && !r_drop && !w_kill;
    w_resp_fault  = w_resp_take && bus.imem_err;
    // Queue occupancy after this cycle's pop/push; one more slot must remain
    // free so the new request (or synthesized entry) always has a home.
    w_level       = {1'b0, r_count} + {2'b0, w_resp_take} - {2'b0, w_pop};
    w_slot_free   = (w_level <= 3'd1);
    w_can_issue   = !reset && (r_state == ST_RUN) && !w_kill && !r_req_busy &&
                    (!r_out || w_resp) && (!r_drop || w_resp) &&
                    !w_resp_fault && w_slot_free;
    w_synth       = w_can_issue && (r_pc[1:0] != 2'b00) && !w_resp_take;
    w_new_req     = w_can_issue && (r_pc[1:0] == 2'b00);
    w_imem_valid  = r_req_busy || w_new_req;
    w_imem_addr   = '0;
    if (r_req_busy)     w_imem_addr = r_req_addr;
    else if (w_new_req) w_imem_addr = r_pc;
    w_accept      = w_imem_valid && bus.imem_ready_in;
    w_acc_stale   = r_req_busy && r_req_stale;
    w_push        = w_resp_take || w_synth;
    w_wr_idx      = r_head ^ r_count[0];

    if (bus.flush)                     w_state_next = ST_RUN;
    else if (w_resp_fault || w_synth)  w_state_next = ST_HALT;

    bus.valid_out      = w_valid_out;
    bus.imem_valid_out = w_imem_valid;
    bus.imem_addr      = w_imem_addr;
    bus.PC_IF          = '0;
    bus.IR_IF          = '0;
    bus.exc_pend_IF    = 1'b0;
    bus.exc_cause_IF   = '0;
    if (w_head_valid) begin
      bus.PC_IF        = r_q_pc[r_head];
      bus.IR_IF        = r_q_ir[r_head];
      bus.exc_pend_IF  = r_q_exc[r_head];
      bus.exc_cause_IF = r_q_cause[r_head];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_ADDR;
      r_out       <= 1'b0;
      r_drop      <= 1'b0;
      r_ret_addr  <= '0;
      r_req_busy  <= 1'b0;
      r_req_addr  <= '0;
      r_req_stale <= 1'b0;
      r_head      <= 1'b0;
      r_count     <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_q_pc[i]    <= '0;
        r_q_ir[i]    <= '0;
        r_q_exc[i]   <= 1'b0;
        r_q_cause[i] <= '0;
      end
    end else begin
      // A stale request keeps the PC at its redirect target when accepted.
      if (bus.flush)                    r_pc <= bus.flush_addr;
      else if (w_jump)                  r_pc <= bus.jump_addr_IF;
      else if (w_accept && !w_acc_stale) r_pc <= r_pc + 32'd4;

      if (w_accept)    r_out <= 1'b1;
      else if (w_resp) r_out <= 1'b0;

      if (w_accept) r_ret_addr <= w_imem_addr;

      // Drop is armed for a request that is in flight across a redirect;
      // a response completing in the redirect cycle is consumed right there.
      r_drop <= (w_accept && (w_kill || w_acc_stale)) ||
                (r_drop && !w_resp) ||
                (w_kill && r_out && !w_resp);

      r_req_busy  <= w_imem_valid && !bus.imem_ready_in;
      r_req_stale <= w_imem_valid && !bus.imem_ready_in && (w_acc_stale || w_kill);
      if (w_new_req) r_req_addr <= r_pc;

      if (w_kill) begin
        r_count <= '0;
      end else begin
        if (w_pop) r_head <= ~r_head;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        if (w_resp_take) begin
          r_q_pc[w_wr_idx]    <= r_ret_addr;
          r_q_ir[w_wr_idx]    <= bus.imem_err ? 32'd0 : bus.imem_rdata;
          r_q_exc[w_wr_idx]   <= bus.imem_err;
          r_q_cause[w_wr_idx] <= bus.imem_err ? CAUSE_ACCESS_FAULT : 32'd0;
        end else if (w_synth) begin
          r_q_pc[w_wr_idx]    <= r_pc;
          r_q_ir[w_wr_idx]    <= '0;
          r_q_exc[w_wr_idx]   <= 1'b1;
          r_q_cause[w_wr_idx] <= CAUSE_MISALIGNED;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. A behavioural instruction
// memory with selectable latency returns addr ^ 32'hA5A5A5A5 (or an access
// fault for err_addr); each step advances one clock and checks outputs.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_ADDR        (32'h0000_0000),
    .CAUSE_MISALIGNED  (32'd0),
    .CAUSE_ACCESS_FAULT(32'd1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          mem_lat = 1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request mid-cycle, then drive the memory response.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    acc = bus.imem_valid_out && bus.imem_ready_in;
    a   = bus.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_valid_in = 1'b0;
    bus.imem_rdata    = '0;
    bus.imem_err      = 1'b0;
    if (m_pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        bus.imem_valid_in = 1'b1;
        bus.imem_rdata    = m_addr ^ 32'hA5A5A5A5;
        bus.imem_err      = (m_addr == err_addr);
        m_pend            = 1'b0;
      end
    end
    if (acc) begin
      m_addr = a;
      if (mem_lat == 1) begin
        bus.imem_valid_in = 1'b1;
        bus.imem_rdata    = a ^ 32'hA5A5A5A5;
        bus.imem_err      = (a == err_addr);
      end else begin
        m_pend = 1'b1;
        m_cnt  = mem_lat - 1;
      end
    end
    #1;
  endtask

  initial begin
    reset             = 1'b1;
    bus.flush         = 1'b0;
    bus.flush_addr    = '0;
    bus.jump_pred_IF  = 1'b0;
    bus.jump_addr_IF  = '0;
    bus.ready_in      = 1'b1;
    bus.imem_ready_in = 1'b1;
    bus.imem_valid_in = 1'b0;
    bus.imem_rdata    = '0;
    bus.imem_err      = 1'b0;

    tick();
    tick();
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_PC_IF", bus.PC_IF, 0);
    check("rst_IR_IF", bus.IR_IF, 0);
    check("rst_exc_pend", bus.exc_pend_IF, 0);
    check("rst_exc_cause", bus.exc_cause_IF, 0);
    check("rst_imem_valid", bus.imem_valid_out, 0);
    check("rst_imem_addr", bus.imem_addr, 0);

    // Sequential fetch, 1-cycle memory
    reset = 1'b0;
    #1;
    check("first_req_valid", bus.imem_valid_out, 1);
    check("first_req_addr", bus.imem_addr, 32'h0);
    tick();
    check("startup_valid_out", bus.valid_out, 0);
    check("second_req_addr", bus.imem_addr, 32'h4);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check("seq_valid", bus.valid_out, 1);
      check("seq_pc", bus.PC_IF, 32'(4 * i));
      check("seq_ir", bus.IR_IF, 32'(4 * i) ^ 32'hA5A5A5A5);
    end

    // Decode stall: queue fills to two entries, requests stop
    bus.ready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_valid", bus.valid_out, 1);
      check("stall_head_pc", bus.PC_IF, 32'hC);
      check("stall_no_req", bus.imem_valid_out, 0);
    end
    bus.ready_in = 1'b1;
    #1;
    check("release_req_addr", bus.imem_addr, 32'h14);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("release_valid", bus.valid_out, 1);
      check("release_pc", bus.PC_IF, 32'h10 + 32'(4 * i));
    end

    // Flush with a request outstanding on a 2-cycle memory
    mem_lat = 2;
    tick();
    check("pre_flush_pc", bus.PC_IF, 32'h1C);
    check("outstanding_no_req", bus.imem_valid_out, 0);
    bus.flush      = 1'b1;
    bus.flush_addr = 32'h200;
    #1;
    check("flush_gates_valid", bus.valid_out, 0);
    tick();
    bus.flush = 1'b0;
    #1;
    check("flush_valid_out", bus.valid_out, 0);
    check("flush_req_valid", bus.imem_valid_out, 1);
    check("flush_req_addr", bus.imem_addr, 32'h200);
    tick();
    check("dropped_resp_1", bus.valid_out, 0);
    tick();
    check("dropped_resp_2", bus.valid_out, 0);
    tick();
    check("flush_tgt_valid", bus.valid_out, 1);
    check("flush_tgt_pc", bus.PC_IF, 32'h200);
    check("flush_tgt_ir", bus.IR_IF, 32'hA5A5A7A5);

    // Predicted jump discards the queued second entry
    mem_lat = 1;
    bus.ready_in = 1'b0;
    tick();
    tick();
    check("jmp_head_pc", bus.PC_IF, 32'h200);
    check("jmp_full_no_req", bus.imem_valid_out, 0);
    bus.ready_in     = 1'b1;
    bus.jump_pred_IF = 1'b1;
    bus.jump_addr_IF = 32'h40;
    tick();
    bus.jump_pred_IF = 1'b0;
    #1;
    check("jmp_valid_out", bus.valid_out, 0);
    check("jmp_req_addr", bus.imem_addr, 32'h40);
    tick();
    check("jmp_gap", bus.valid_out, 0);
    tick();
    check("jmp_tgt_valid", bus.valid_out, 1);
    check("jmp_tgt_pc", bus.PC_IF, 32'h40);
    check("jmp_tgt_ir", bus.IR_IF, 32'hA5A5A5E5);

    // Jump while a response completes: that response is discarded
    bus.jump_pred_IF = 1'b1;
    bus.jump_addr_IF = 32'h80;
    tick();
    bus.jump_pred_IF = 1'b0;
    #1;
    check("jmp2_valid_out", bus.valid_out, 0);
    check("jmp2_req_addr", bus.imem_addr, 32'h80);
    tick();
    tick();
    check("jmp2_tgt_pc", bus.PC_IF, 32'h80);
    check("jmp2_tgt_ir", bus.IR_IF, 32'hA5A5A525);

    // Misaligned flush target
    bus.flush      = 1'b1;
    bus.flush_addr = 32'h102;
    tick();
    bus.flush = 1'b0;
    #1;
    check("mis_no_req", bus.imem_valid_out, 0);
    check("mis_valid_0", bus.valid_out, 0);
    tick();
    check("mis_valid", bus.valid_out, 1);
    check("mis_pc", bus.PC_IF, 32'h102);
    check("mis_ir", bus.IR_IF, 0);
    check("mis_exc", bus.exc_pend_IF, 1);
    check("mis_cause", bus.exc_cause_IF, 0);
    check("mis_halt_req", bus.imem_valid_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mis_halt_valid", bus.valid_out, 0);
      check("mis_halt_no_req", bus.imem_valid_out, 0);
    end

    // Access fault response
    err_addr       = 32'h20;
    bus.flush      = 1'b1;
    bus.flush_addr = 32'h20;
    tick();
    bus.flush = 1'b0;
    #1;
    check("err_req_valid", bus.imem_valid_out, 1);
    check("err_req_addr", bus.imem_addr, 32'h20);
    tick();
    check("err_no_next_req", bus.imem_valid_out, 0);
    tick();
    check("err_valid", bus.valid_out, 1);
    check("err_pc", bus.PC_IF, 32'h20);
    check("err_ir", bus.IR_IF, 0);
    check("err_exc", bus.exc_pend_IF, 1);
    check("err_cause", bus.exc_cause_IF, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("err_halt_valid", bus.valid_out, 0);
      check("err_halt_no_req", bus.imem_valid_out, 0);
    end

    // Flush while a request is held un-accepted
    err_addr       = 32'hFFFF_FFFF;
    bus.flush      = 1'b1;
    bus.flush_addr = 32'h300;
    tick();
    bus.flush         = 1'b0;
    bus.imem_ready_in = 1'b0;
    #1;
    check("hold_req_valid", bus.imem_valid_out, 1);
    check("hold_req_addr", bus.imem_addr, 32'h300);
    tick();
    check("hold_req_addr_2", bus.imem_addr, 32'h300);
    bus.flush      = 1'b1;
    bus.flush_addr = 32'h400;
    tick();
    bus.flush = 1'b0;
    #1;
    check("stale_req_valid", bus.imem_valid_out, 1);
    check("stale_req_addr", bus.imem_addr, 32'h300);
    bus.imem_ready_in = 1'b1;
    tick();
    check("stale_drop_valid", bus.valid_out, 0);
    check("stale_next_addr", bus.imem_addr, 32'h400);
    tick();
    check("stale_gap", bus.valid_out, 0);
    tick();
    check("stale_tgt_valid", bus.valid_out, 1);
    check("stale_tgt_pc", bus.PC_IF, 32'h400);
    check("stale_tgt_ir", bus.IR_IF, 32'hA5A5A1A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
